multicycle_controller: RTL and testbench

//  Control FSM for the multicycle RV32 datapath (shared memory, IR, OldPC, ALUOut, Data regs).

---
 rtl/mc_pkg.sv | 127 ++++++++++++
 rtl/mc_imm_decoder.sv | 11 +
 rtl/multicycle_controller.sv | 103 ++++++++++
 tb/tb_multicycle_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode and mux-select encodings shared by the multicycle controller
package mc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWRITE = 4'd4;
    localparam logic [3:0] S_MEMWB    = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BEQ      = 4'd8;
    localparam logic [3:0] S_EXECUTEI = 4'd9;

    typedef enum logic [3:0] {
        FETCH    = S_FETCH,
        DECODE   = S_DECODE,
        MEMADR   = S_MEMADR,
        MEMREAD  = S_MEMREAD,
        MEMWRITE = S_MEMWRITE,
        MEMWB    = S_MEMWB,
        EXECUTER = S_EXECUTER,
        ALUWB    = S_ALUWB,
        BEQ      = S_BEQ,
        EXECUTEI = S_EXECUTEI
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       fetch;
        logic       branch;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore output table; fetch/branch are qualifiers later gated by mem_ready/Zero
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: c.reg_write = 1'b1;
            BEQ: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_imm_decoder.sv
// rtl/mc_imm_decoder.sv - opcode to immediate-format select, independent of FSM state
module mc_imm_decoder
    import mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    assign imm_src = imm_sel(op);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32 control FSM with memory handshake and timeout
// Define MC_ITYPE_EN to accept I-type ALU instructions (op 0010011).
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_t     state;
    state_t     state_n;
    ctrl_t      ctrl;
    logic [7:0] wait_cnt;
    logic       mem_done;
    logic       mem_abort;

    // Handshake only counts while the registered request is up, so a stray mem_ready is ignored
    assign mem_done  = ctrl.mem_req & mem_ready;
    assign mem_abort = ctrl.mem_req & ~mem_ready & (wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_comb begin
        state_n = state;
        case (state)
            FETCH: begin
                if (mem_done) state_n = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_R:         state_n = EXECUTER;
                    OP_BEQ:       state_n = BEQ;
`ifdef MC_ITYPE_EN
                    OP_I:         state_n = EXECUTEI;
`endif
                    default:      state_n = FETCH;
                endcase
            end
            MEMADR:   state_n = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                if (mem_done)       state_n = MEMWB;
                else if (mem_abort) state_n = FETCH;
            end
            MEMWRITE: begin
                if (mem_done || mem_abort) state_n = FETCH;
            end
            EXECUTER, EXECUTEI: state_n = ALUWB;
            default:            state_n = FETCH;
        endcase
    end

    // Outputs are registered from the next state so reset forces every enable low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            ctrl     <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_n;
            ctrl  <= state_ctrl(state_n);
            if (state_n != state || mem_abort)
                wait_cnt <= '0;
            else if (ctrl.mem_req && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign mem_req     = ctrl.mem_req;
    assign AdrSrc      = ctrl.adr_src;
    assign MemWrite    = ctrl.mem_write;
    assign RegWrite    = ctrl.reg_write;
    assign ResultSrc   = ctrl.result_src;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign IRWrite     = ctrl.fetch & mem_done;
    assign PCWrite     = (ctrl.fetch & mem_done) | (ctrl.branch & Zero);
    assign illegal_op  = (state == DECODE) && (state_n == FETCH);
    assign mem_timeout = mem_abort;

    mc_imm_decoder u_imm_decoder (
        .op      (op),
        .imm_src (ImmSrc)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed and randomized check of multicycle_controller
module tb_multicycle_controller;

    localparam int TMO = 16;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011;
    localparam logic [6:0] BQ = 7'b1100011;
    localparam logic [6:0] IT = 7'b0010011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = LW;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       illegal_op, mem_timeout;

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;

    multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .PCWrite     (PCWrite),
        .AdrSrc      (AdrSrc),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ImmSrc      (ImmSrc),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            SW:      return 2'b01;
            BQ:      return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit legal(input logic [6:0] o);
        if (o == LW || o == SW || o == RT || o == BQ) return 1'b1;
`ifdef MC_ITYPE_EN
        if (o == IT) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [15:0] ev(input bit mreq, input bit mw, input bit irw, input bit rw,
                                       input bit pcw, input bit adr, input bit ill, input bit to,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] alu);
        return {mreq, mw, irw, rw, pcw, adr, ill, to, res, a, b, alu};
    endfunction

    function automatic logic [17:0] obs();
        return {mem_req, MemWrite, IRWrite, RegWrite, PCWrite, AdrSrc, illegal_op, mem_timeout,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, ncyc, o, e);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, sample 1 time unit later
    task automatic cyc(input bit rdy, input bit z, input logic [15:0] e, input string tag);
        mem_ready = rdy;
        Zero = z;
        #1;
        check(tag, 32'(obs()), 32'({e, imm_of(op)}));
        ncyc++;
        @(negedge clk);
    endtask

    // Memory access: ready after 'waits' idle cycles, unless that exceeds the timeout window
    task automatic mem_phase(input bit is_fetch, input bit is_store, input int waits,
                             input string tag, output bit ok);
        int n;
        bit rdy;
        bit to;
        ok = (waits <= TMO - 1);
        n = ok ? waits + 1 : TMO;
        for (int i = 0; i < n; i++) begin
            rdy = ok && (i == waits);
            to = !ok && (i == TMO - 1);
            if (is_fetch)
                cyc(rdy, rb(), ev(1, 0, rdy, 0, rdy, 0, 0, to, 2'b10, 2'b00, 2'b10, 2'b00), tag);
            else
                cyc(rdy, rb(), ev(1, is_store, 0, 0, 0, 1, 0, to, 2'b00, 2'b00, 2'b00, 2'b00), tag);
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input int wf, input int wm, input int zq,
                             output int cycles);
        bit ok;
        bit z;
        int c0;
        c0 = ncyc;
        op = o;
        mem_phase(1'b1, 1'b0, wf, "fetch", ok);
        if (ok) begin
            cyc(rb(), rb(), ev(0, 0, 0, 0, 0, 0, !legal(o), 0, 2'b00, 2'b01, 2'b01, 2'b00), "decode");
            if (legal(o)) begin
                if (o == LW || o == SW) begin
                    cyc(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00), "memadr");
                    mem_phase(1'b0, o == SW, wm, "memdata", ok);
                    if (ok && o == LW)
                        cyc(rb(), rb(), ev(0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00), "memwb");
                end else if (o == BQ) begin
                    z = (zq < 0) ? rb() : zq[0];
                    cyc(rb(), z, ev(0, 0, 0, 0, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01), "beq");
                end else begin
                    cyc(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                                       (o == IT) ? 2'b01 : 2'b00, 2'b10), "execute");
                    cyc(rb(), rb(), ev(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), "aluwb");
                end
            end
        end
        cycles = ncyc - c0;
    endtask

    // Hold reset across a rising edge, release just before the next one
    task automatic release_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        #4 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cycles;
        int w;
        bit ok;
        logic [6:0] o;

        mem_ready = 1'b1;
        Zero = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", 32'(obs()), 32'({16'h0, imm_of(op)}));
        release_reset();

        run_instr(LW, 0, 0, -1, cycles); check("lat_lw", 32'(cycles), 32'd5);
        run_instr(SW, 0, 0, -1, cycles); check("lat_sw", 32'(cycles), 32'd4);
        run_instr(RT, 0, 0, -1, cycles); check("lat_r", 32'(cycles), 32'd4);
        run_instr(BQ, 0, 0, 1, cycles);  check("lat_beq_taken", 32'(cycles), 32'd3);
        run_instr(BQ, 0, 0, 0, cycles);  check("lat_beq_not", 32'(cycles), 32'd3);
        run_instr(RT, 3, 0, -1, cycles); check("lat_fetch_wait3", 32'(cycles), 32'd7);
        run_instr(SW, 0, 1000, -1, cycles); check("lat_sw_timeout", 32'(cycles), 32'(3 + TMO));
        run_instr(LW, 0, TMO - 1, -1, cycles); check("lat_lw_last_ready", 32'(cycles), 32'(4 + TMO));
        run_instr(RT, 40, 0, -1, cycles); check("lat_fetch_timeout", 32'(cycles), 32'(TMO));
        run_instr(IT, 0, 0, -1, cycles); check("lat_itype", 32'(cycles), legal(IT) ? 32'd4 : 32'd2);
        run_instr(7'b1111111, 0, 0, -1, cycles); check("lat_illegal", 32'(cycles), 32'd2);

        op = LW;
        mem_phase(1'b1, 1'b0, 0, "rst_fetch", ok);
        cyc(0, rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00), "rst_decode");
        cyc(0, rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00), "rst_memadr");
        repeat (2) cyc(0, rb(), ev(1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), "rst_memread");
        mem_ready = 1'b1;
        Zero = 1'b1;
        reset = 1'b1;
        #1 check("rst_async", 32'(obs()), 32'({16'h0, imm_of(op)}));
        release_reset();
        cyc(0, 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00), "rst_fetch_req");
        run_instr(LW, 0, 0, -1, cycles); check("lat_lw_after_rst", 32'(cycles), 32'd5);

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 5))
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = BQ;
                4: o = IT;
                default: o = 7'($urandom);
            endcase
            w = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(13, 18));
            run_instr(o, ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : w, w, -1, cycles);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
